intersection_scheduler: RTL

Two-approach intersection controller that sequences the north-south (NS) and east-west (EW) signal heads, an all-red clearance interval and a pedestrian walk phase from an internal 1 Hz tick. It is the top-level sequencer for the board's light outputs. It takes a debounced pedestrian pulse and an EW vehicle-presence sensor, and drives six registered lamp outputs plus walk/wait indicators.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/tick_gen.sv | 37 +++
 rtl/intersection_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controllers: sequencer states, approach
// direction and {red,yellow,green} lamp patterns.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      AR_NS = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      AR_EW = 3'd5,
      WALK  = 3'd6
   } state_e;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_e;

   localparam int unsigned RYG_W = 3;

   localparam logic [RYG_W-1:0] RYG_RED = 3'b100;
   localparam logic [RYG_W-1:0] RYG_YEL = 3'b010;
   localparam logic [RYG_W-1:0] RYG_GRN = 3'b001;

endpackage

// File: rtl/tick_gen.sv
// Divides clk down to a one-cycle tick pulse every TICK_DIV cycles.
module tick_gen #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);

   if (TICK_DIV < 2) begin : g_bad_div
      $error("tick_gen: TICK_DIV must be at least 2");
   end

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
         cnt_d = '0;
      end
   end

   // tick is a flop that mirrors (cnt_q == TICK_DIV-1) exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tick  <= (cnt_d == CNT_W'(TICK_DIV - 1));
      end
   end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection sequencer: NS/EW greens, yellows, all-red
// clearance and a pedestrian walk phase, all timed in ticks.
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned GREEN_S  = 5,
   parameter int unsigned YELLOW_S = 3,
   parameter int unsigned ALLRED_S = 1,
   parameter int unsigned WALK_S   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ped_req,
   input  logic ew_car,
   output logic ns_red,
   output logic ns_yellow,
   output logic ns_green,
   output logic ew_red,
   output logic ew_yellow,
   output logic ew_green,
   output logic walk_light,
   output logic ped_wait
);

   localparam int unsigned SEC_W = 4;

   if (GREEN_S < 1 || GREEN_S > 15 || YELLOW_S < 1 || YELLOW_S > 15 ||
       ALLRED_S < 1 || ALLRED_S > 15 || WALK_S < 1 || WALK_S > 15) begin : g_bad_len
      $error("intersection_scheduler: phase lengths must be in 1..15");
   end

   logic             tick;
   state_e           state_q, state_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic [SEC_W-1:0] last_sec_c;
   logic             illegal_c;
   dir_e             dir_q, dir_d;
   logic             ped_q, ped_d;
   logic [RYG_W-1:0] ns_ryg_c, ew_ryg_c;
   logic             walk_c;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Final sec_count value of the current state.
   always_comb begin
      last_sec_c = '0;
      illegal_c  = 1'b0;
      case (state_q)
         NS_G, EW_G:   last_sec_c = SEC_W'(GREEN_S - 1);
         NS_Y, EW_Y:   last_sec_c = SEC_W'(YELLOW_S - 1);
         AR_NS, AR_EW: last_sec_c = SEC_W'(ALLRED_S - 1);
         WALK:         last_sec_c = SEC_W'(WALK_S - 1);
         default:      illegal_c  = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      dir_d   = dir_q;
      ped_d   = ped_q | ped_req;

      if (tick) begin
         if (sec_q != last_sec_c) begin
            sec_d = sec_q + SEC_W'(1);
         end else begin
            sec_d = '0;
            case (state_q)
               // NS rests in green (sec held) until EW traffic or a pedestrian.
               NS_G: begin
                  if (ew_car || ped_q) state_d = NS_Y;
                  else                 sec_d   = sec_q;
               end
               NS_Y: begin
                  state_d = AR_NS;
                  dir_d   = DIR_EW;
               end
               AR_NS:   state_d = ped_q ? WALK : EW_G;
               EW_G:    state_d = EW_Y;
               EW_Y: begin
                  state_d = AR_EW;
                  dir_d   = DIR_NS;
               end
               AR_EW:   state_d = ped_q ? WALK : NS_G;
               WALK:    state_d = (dir_q == DIR_NS) ? NS_G : EW_G;
               default: state_d = AR_EW;
            endcase
         end
      end

      if (illegal_c) begin
         state_d = AR_EW;
         sec_d   = '0;
      end

      // Entering WALK serves the request; a new request in that cycle survives.
      if (state_d == WALK && state_q != WALK) begin
         ped_d = ped_req;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= AR_EW;
         sec_q   <= '0;
         dir_q   <= DIR_NS;
         ped_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         dir_q   <= dir_d;
         ped_q   <= ped_d;
      end
   end

   always_comb begin
      ns_ryg_c = RYG_RED;
      ew_ryg_c = RYG_RED;
      walk_c   = 1'b0;
      case (state_q)
         NS_G:    ns_ryg_c = RYG_GRN;
         NS_Y:    ns_ryg_c = RYG_YEL;
         EW_G:    ew_ryg_c = RYG_GRN;
         EW_Y:    ew_ryg_c = RYG_YEL;
         WALK:    walk_c   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {ns_red, ns_yellow, ns_green} <= RYG_RED;
         {ew_red, ew_yellow, ew_green} <= RYG_RED;
         walk_light                    <= 1'b0;
         ped_wait                      <= 1'b0;
      end else begin
         {ns_red, ns_yellow, ns_green} <= ns_ryg_c;
         {ew_red, ew_yellow, ew_green} <= ew_ryg_c;
         walk_light                    <= walk_c;
         ped_wait                      <= ped_q;
      end
   end

endmodule
